// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP sequencer: channel addresses, widths,
// FSM state encoding and the DRP command payload.
package xadc_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CHAN_W   = 5;
  localparam int unsigned IDX_W    = 2;

  // DRP status addresses of the four scanned auxiliary channels
  localparam logic [ADDR_W-1:0] CH0_ADDR_DEF = 7'h12; // VAUX2
  localparam logic [ADDR_W-1:0] CH1_ADDR_DEF = 7'h13; // VAUX3
  localparam logic [ADDR_W-1:0] CH2_ADDR_DEF = 7'h1A; // VAUX10
  localparam logic [ADDR_W-1:0] CH3_ADDR_DEF = 7'h1B; // VAUX11

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } drp_state_e;

  // One DRP access as presented on daddr/dwe/di
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } drp_cmd_t;

  // The converter result sits in the upper 12 bits of the status register
  function automatic logic [SAMPLE_W-1:0] sample_of(input logic [DATA_W-1:0] d);
    return d[DATA_W-1 -: SAMPLE_W];
  endfunction

endpackage

// File: rtl/drp_watchdog.sv
// Transaction watchdog for the DRP port.
//   clk, rst_n  : clock, async active-low reset
//   i_start     : load the counter with 1 (first wait cycle reads 1)
//   i_clear     : stop and zero the counter
//   o_expire_c  : high in the last cycle before the count would reach TIMEOUT_CYC
module drp_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter runs only while non-zero, so an idle watchdog never expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Flagging one count early lets the registered abort land in the cycle the
  // timer reads TIMEOUT_CYC
  assign o_expire_c = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Owns the XADC DRP port: serves eoc-triggered scan reads of four aux channels
// and a user register-access port, one transaction at a time.
//   CLK100MHZ, CPU_RESETN          : clock, async active-low reset
//   eoc_in, channel_in             : end-of-conversion strobe and channel number
//   drp_den/dwe/daddr/di/do/drdy   : DRP master side
//   user_req/we/addr/wdata         : user request (held until user_ack)
//   user_ack, user_rdata           : user completion pulse and last read data
//   sample_valid/chan/data         : scan result pulse with channel index
//   overrun                        : sticky, a pending scan was overwritten
//   timeout_err                    : pulse, a transaction was aborted
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter logic [6:0]  CH0_ADDR    = CH0_ADDR_DEF,
  parameter logic [6:0]  CH1_ADDR    = CH1_ADDR_DEF,
  parameter logic [6:0]  CH2_ADDR    = CH2_ADDR_DEF,
  parameter logic [6:0]  CH3_ADDR    = CH3_ADDR_DEF,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  input  logic        user_req,
  input  logic        user_we,
  input  logic [6:0]  user_addr,
  input  logic [15:0] user_wdata,
  output logic        user_ack,
  output logic [15:0] user_rdata,
  output logic        sample_valid,
  output logic [1:0]  sample_chan,
  output logic [11:0] sample_data,
  output logic        overrun,
  output logic        timeout_err
);

  drp_state_e          r_state, w_state_nxt;

  logic                r_scan_pend;
  logic [IDX_W-1:0]    r_scan_idx;
  logic                r_overrun;

  logic                w_eoc_match;
  logic [IDX_W-1:0]    w_eoc_idx;

  logic                r_den, w_den_nxt;
  drp_cmd_t            r_cmd, w_cmd_nxt;
  logic                r_ack, w_ack_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_sv, w_sv_nxt;
  logic [IDX_W-1:0]    r_chan, w_chan_nxt;
  logic [SAMPLE_W-1:0] r_sdata, w_sdata_nxt;
  logic                r_to, w_to_nxt;

  // Context of the transaction in flight
  logic                r_cur_scan, w_cur_scan_nxt;
  logic [IDX_W-1:0]    r_cur_idx, w_cur_idx_nxt;
  logic                r_cur_we, w_cur_we_nxt;

  logic                w_wd_start, w_wd_clear, w_wd_expire;

  function automatic logic [ADDR_W-1:0] ch_addr(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    return CH0_ADDR;
      2'd1:    return CH1_ADDR;
      2'd2:    return CH2_ADDR;
      default: return CH3_ADDR;
    endcase
  endfunction

  // Map the XADC channel number onto a scan index; other channels are ignored
  always_comb begin
    w_eoc_match = 1'b0;
    w_eoc_idx   = '0;
    if (eoc_in) begin
      if (channel_in == CH0_ADDR[4:0]) begin
        w_eoc_match = 1'b1;
        w_eoc_idx   = 2'd0;
      end else if (channel_in == CH1_ADDR[4:0]) begin
        w_eoc_match = 1'b1;
        w_eoc_idx   = 2'd1;
      end else if (channel_in == CH2_ADDR[4:0]) begin
        w_eoc_match = 1'b1;
        w_eoc_idx   = 2'd2;
      end else if (channel_in == CH3_ADDR[4:0]) begin
        w_eoc_match = 1'b1;
        w_eoc_idx   = 2'd3;
      end
    end
  end

  // One-deep scan request slot, captured regardless of FSM state
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_scan_pend <= 1'b0;
      r_scan_idx  <= '0;
      r_overrun   <= 1'b0;
    end else if (w_eoc_match) begin
      r_scan_pend <= 1'b1;
      r_scan_idx  <= w_eoc_idx;
      if (r_scan_pend) begin
        r_overrun <= 1'b1;
      end
    end else if (r_state == ST_ISSUE && r_cur_scan) begin
      r_scan_pend <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    w_state_nxt    = r_state;
    w_den_nxt      = 1'b0;
    w_cmd_nxt      = '0;
    w_ack_nxt      = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_sv_nxt       = 1'b0;
    w_chan_nxt     = r_chan;
    w_sdata_nxt    = r_sdata;
    w_to_nxt       = 1'b0;
    w_cur_scan_nxt = r_cur_scan;
    w_cur_idx_nxt  = r_cur_idx;
    w_cur_we_nxt   = r_cur_we;
    w_wd_start     = 1'b0;
    w_wd_clear     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_scan_pend) begin
          w_state_nxt    = ST_ISSUE;
          w_den_nxt      = 1'b1;
          w_cmd_nxt.addr = ch_addr(r_scan_idx);
          w_cur_scan_nxt = 1'b1;
          w_cur_idx_nxt  = r_scan_idx;
          w_cur_we_nxt   = 1'b0;
        end else if (!w_eoc_match && user_req) begin
          // A same-cycle eoc becomes pending next cycle and goes first
          w_state_nxt    = ST_ISSUE;
          w_den_nxt      = 1'b1;
          w_cmd_nxt.we   = user_we;
          w_cmd_nxt.addr = user_addr;
          w_cmd_nxt.data = user_wdata;
          w_cur_scan_nxt = 1'b0;
          w_cur_we_nxt   = user_we;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_wd_start  = 1'b1;
      end
      ST_WAIT: begin
        if (drp_drdy) begin
          w_state_nxt = ST_DONE;
          w_wd_clear  = 1'b1;
          if (r_cur_scan) begin
            w_sv_nxt    = 1'b1;
            w_chan_nxt  = r_cur_idx;
            w_sdata_nxt = sample_of(drp_do);
          end else begin
            w_ack_nxt = 1'b1;
            if (!r_cur_we) begin
              w_rdata_nxt = drp_do;
            end
          end
        end else if (w_wd_expire) begin
          w_state_nxt = ST_IDLE;
          w_wd_clear  = 1'b1;
          w_to_nxt    = 1'b1;
          w_ack_nxt   = !r_cur_scan;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output and transaction-context registers
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_den      <= 1'b0;
      r_cmd      <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_sv       <= 1'b0;
      r_chan     <= '0;
      r_sdata    <= '0;
      r_to       <= 1'b0;
      r_cur_scan <= 1'b0;
      r_cur_idx  <= '0;
      r_cur_we   <= 1'b0;
    end else begin
      r_den      <= w_den_nxt;
      r_cmd      <= w_cmd_nxt;
      r_ack      <= w_ack_nxt;
      r_rdata    <= w_rdata_nxt;
      r_sv       <= w_sv_nxt;
      r_chan     <= w_chan_nxt;
      r_sdata    <= w_sdata_nxt;
      r_to       <= w_to_nxt;
      r_cur_scan <= w_cur_scan_nxt;
      r_cur_idx  <= w_cur_idx_nxt;
      r_cur_we   <= w_cur_we_nxt;
    end
  end

  drp_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk        (CLK100MHZ),
    .rst_n      (CPU_RESETN),
    .i_start    (w_wd_start),
    .i_clear    (w_wd_clear),
    .o_expire_c (w_wd_expire)
  );

  assign drp_den      = r_den;
  assign drp_dwe      = r_cmd.we;
  assign drp_daddr    = r_cmd.addr;
  assign drp_di       = r_cmd.data;
  assign user_ack     = r_ack;
  assign user_rdata   = r_rdata;
  assign sample_valid = r_sv;
  assign sample_chan  = r_chan;
  assign sample_data  = r_sdata;
  assign overrun      = r_overrun;
  assign timeout_err  = r_to;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer: scan reads, user accesses, priority,
// overrun, timeout and mid-transaction reset.
module tb_xadc_drp_sequencer;

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        user_req;
  logic        user_we;
  logic [6:0]  user_addr;
  logic [15:0] user_wdata;
  logic        user_ack;
  logic [15:0] user_rdata;
  logic        sample_valid;
  logic [1:0]  sample_chan;
  logic [11:0] sample_data;
  logic        overrun;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;
  int n_den = 0;
  int n_sv  = 0;
  int n_ack = 0;

  xadc_drp_sequencer dut (
    .CLK100MHZ    (CLK100MHZ),
    .CPU_RESETN   (CPU_RESETN),
    .eoc_in       (eoc_in),
    .channel_in   (channel_in),
    .drp_den      (drp_den),
    .drp_dwe      (drp_dwe),
    .drp_daddr    (drp_daddr),
    .drp_di       (drp_di),
    .drp_do       (drp_do),
    .drp_drdy     (drp_drdy),
    .user_req     (user_req),
    .user_we      (user_we),
    .user_addr    (user_addr),
    .user_wdata   (user_wdata),
    .user_ack     (user_ack),
    .user_rdata   (user_rdata),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_data  (sample_data),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Pulse counters, sampled mid-cycle
  always @(negedge CLK100MHZ) begin
    if (CPU_RESETN) begin
      if (drp_den)      n_den = n_den + 1;
      if (sample_valid) n_sv  = n_sv + 1;
      if (user_ack)     n_ack = n_ack + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic eoc(input logic [4:0] ch);
    eoc_in     = 1'b1;
    channel_in = ch;
    step();
    eoc_in     = 1'b0;
    channel_in = 5'h00;
  endtask

  task automatic drdy(input logic [15:0] d);
    drp_drdy = 1'b1;
    drp_do   = d;
    step();
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;
  endtask

  int b_den, b_sv, b_ack, cyc;
  bit got;

  initial begin
    CPU_RESETN = 1'b0;
    eoc_in = 1'b0; channel_in = 5'h00;
    drp_do = 16'h0000; drp_drdy = 1'b0;
    user_req = 1'b0; user_we = 1'b0; user_addr = 7'h00; user_wdata = 16'h0000;
    step(); step();
    chk("rst_den",   {31'd0, drp_den}, 32'd0);
    chk("rst_daddr", {25'd0, drp_daddr}, 32'd0);
    chk("rst_sdata", {20'd0, sample_data}, 32'd0);
    chk("rst_ovr",   {31'd0, overrun}, 32'd0);
    CPU_RESETN = 1'b1;
    step(); step();

    // 1: scan of channel 0x12, drdy 4 cycles after den
    b_sv = n_sv;
    eoc(5'h12);
    chk("t1_den_n1", {31'd0, drp_den}, 32'd0);
    step();
    chk("t1_den_n2", {31'd0, drp_den}, 32'd1);
    chk("t1_daddr",  {25'd0, drp_daddr}, 32'h12);
    chk("t1_dwe",    {31'd0, drp_dwe}, 32'd0);
    step();
    chk("t1_daddr_wait", {25'd0, drp_daddr}, 32'd0);
    step(); step();
    drdy(16'hABC0);
    chk("t1_sv",    {31'd0, sample_valid}, 32'd1);
    chk("t1_chan",  {30'd0, sample_chan}, 32'd0);
    chk("t1_sdata", {20'd0, sample_data}, 32'hABC);
    step();
    chk("t1_sv_off",  {31'd0, sample_valid}, 32'd0);
    chk("t1_hold",    {20'd0, sample_data}, 32'hABC);
    chk("t1_sv_cnt",  n_sv - b_sv, 32'd1);

    // 2: user write, drdy 2 cycles after den
    b_sv = n_sv; b_ack = n_ack;
    user_req = 1'b1; user_we = 1'b1; user_addr = 7'h41; user_wdata = 16'h2000;
    step();
    chk("t2_den",   {31'd0, drp_den}, 32'd1);
    chk("t2_dwe",   {31'd0, drp_dwe}, 32'd1);
    chk("t2_daddr", {25'd0, drp_daddr}, 32'h41);
    chk("t2_di",    {16'd0, drp_di}, 32'h2000);
    step();
    drdy(16'h0000);
    chk("t2_ack",   {31'd0, user_ack}, 32'd1);
    chk("t2_rdata", {16'd0, user_rdata}, 32'd0);
    user_req = 1'b0; user_we = 1'b0;
    step();
    chk("t2_ack_off", {31'd0, user_ack}, 32'd0);
    chk("t2_ack_cnt", n_ack - b_ack, 32'd1);
    chk("t2_sv_cnt",  n_sv - b_sv, 32'd0);

    // 3: same-cycle eoc (0x1B) and user read of 0x00: scan first
    b_den = n_den;
    user_req = 1'b1; user_we = 1'b0; user_addr = 7'h00;
    eoc(5'h1B);
    chk("t3_den_c1", {31'd0, drp_den}, 32'd0);
    step();
    chk("t3_scan_den",   {31'd0, drp_den}, 32'd1);
    chk("t3_scan_daddr", {25'd0, drp_daddr}, 32'h1B);
    step();
    drdy(16'h5670);
    chk("t3_sv",    {31'd0, sample_valid}, 32'd1);
    chk("t3_chan",  {30'd0, sample_chan}, 32'd3);
    chk("t3_sdata", {20'd0, sample_data}, 32'h567);
    step(); step();
    chk("t3_user_den",   {31'd0, drp_den}, 32'd1);
    chk("t3_user_daddr", {25'd0, drp_daddr}, 32'h00);
    chk("t3_user_dwe",   {31'd0, drp_dwe}, 32'd0);
    step();
    drdy(16'h1234);
    chk("t3_ack",   {31'd0, user_ack}, 32'd1);
    chk("t3_rdata", {16'd0, user_rdata}, 32'h1234);
    user_req = 1'b0;
    step();
    chk("t3_den_cnt", n_den - b_den, 32'd2);

    // 4: overrun: 0x12, then 0x13 during WAIT, then 0x1A before service
    b_sv = n_sv; b_den = n_den;
    eoc(5'h12);
    step();
    chk("t4_daddr0", {25'd0, drp_daddr}, 32'h12);
    step();
    eoc(5'h13);
    chk("t4_ovr0", {31'd0, overrun}, 32'd0);
    eoc(5'h1A);
    chk("t4_ovr1", {31'd0, overrun}, 32'd1);
    drdy(16'h1110);
    chk("t4_chan_a",  {30'd0, sample_chan}, 32'd0);
    chk("t4_sdata_a", {20'd0, sample_data}, 32'h111);
    step(); step();
    chk("t4_den_b",   {31'd0, drp_den}, 32'd1);
    chk("t4_daddr_b", {25'd0, drp_daddr}, 32'h1A);
    step();
    drdy(16'h2220);
    chk("t4_chan_b",  {30'd0, sample_chan}, 32'd2);
    chk("t4_sdata_b", {20'd0, sample_data}, 32'h222);
    step(); step(); step(); step();
    chk("t4_sv_cnt",  n_sv - b_sv, 32'd2);
    chk("t4_den_cnt", n_den - b_den, 32'd2);

    // 5a: scan timeout, late drdy ignored
    b_sv = n_sv;
    eoc(5'h13);
    step();
    chk("t5_den", {31'd0, drp_den}, 32'd1);
    for (int i = 1; i <= 63; i++) step();
    chk("t5_to_early", {31'd0, timeout_err}, 32'd0);
    step();
    chk("t5_to", {31'd0, timeout_err}, 32'd1);
    b_den = n_den;
    drdy(16'hFFF0);
    chk("t5_to_off", {31'd0, timeout_err}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("t5_sv_cnt",  n_sv - b_sv, 32'd0);
    chk("t5_den_cnt", n_den - b_den, 32'd0);

    // 5b: user read timeout: ack with user_rdata unchanged
    user_req = 1'b1; user_we = 1'b0; user_addr = 7'h05;
    step();
    chk("t5u_den", {31'd0, drp_den}, 32'd1);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 80) begin
      step();
      cyc = cyc + 1;
      if (user_ack) got = 1'b1;
    end
    chk("t5u_ack_lat", cyc, 32'd64);
    chk("t5u_to",      {31'd0, timeout_err}, 32'd1);
    chk("t5u_rdata",   {16'd0, user_rdata}, 32'h1234);
    user_req = 1'b0;
    step(); step();

    // 6: reset during WAIT, drdy after release
    eoc(5'h12);
    step();
    chk("t6_den", {31'd0, drp_den}, 32'd1);
    step();
    b_den = n_den; b_sv = n_sv;
    CPU_RESETN = 1'b0;
    #1;
    chk("t6_rst_ovr",   {31'd0, overrun}, 32'd0);
    chk("t6_rst_rdata", {16'd0, user_rdata}, 32'd0);
    chk("t6_rst_sdata", {20'd0, sample_data}, 32'd0);
    chk("t6_rst_chan",  {30'd0, sample_chan}, 32'd0);
    step(); step();
    CPU_RESETN = 1'b1;
    step();
    drdy(16'h7770);
    for (int i = 0; i < 10; i++) step();
    chk("t6_den_cnt", n_den - b_den, 32'd0);
    chk("t6_sv_cnt",  n_sv - b_sv, 32'd0);
    eoc(5'h1B);
    step();
    chk("t6_new_den",   {31'd0, drp_den}, 32'd1);
    chk("t6_new_daddr", {25'd0, drp_daddr}, 32'h1B);
    step();
    drdy(16'h4560);
    chk("t6_new_chan",  {30'd0, sample_chan}, 32'd3);
    chk("t6_new_sdata", {20'd0, sample_data}, 32'h456);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
